// File: rtl/fxu_reservation_station.sv
// Per-FXU reservation station: collapsing queue of dispatched instructions that
// captures pending operands from the CDB and issues the oldest fully-ready entry.
module fxu_reservation_station #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_instr_valid,
   input  logic [TAG_W-1:0]  in_rob_idx,
   input  logic              in_a_valid,
   input  logic [DATA_W-1:0] in_a_value,
   input  logic [TAG_W-1:0]  in_a_owner,
   input  logic              in_b_valid,
   input  logic [DATA_W-1:0] in_b_value,
   input  logic [TAG_W-1:0]  in_b_owner,
   input  logic [3:0]        in_opcode,
   input  logic [7:0]        in_i,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_value,
   output logic              full,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TAG_W-1:0]  out_rob_idx,
   output logic [DATA_W-1:0] out_a_value,
   output logic [DATA_W-1:0] out_b_value,
   output logic [3:0]        out_opcode,
   output logic [7:0]        out_i
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned OPC_W = 4;
   localparam int unsigned IMM_W = 8;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  rob_idx;
      logic              a_rdy;
      logic [DATA_W-1:0] a_val;
      logic [TAG_W-1:0]  a_tag;
      logic              b_rdy;
      logic [DATA_W-1:0] b_val;
      logic [TAG_W-1:0]  b_tag;
      logic [OPC_W-1:0]  opcode;
      logic [IMM_W-1:0]  imm;
   } entry_t;

   entry_t            ent_q [DEPTH];
   entry_t            ent_w [DEPTH];
   entry_t            ent_d [DEPTH];
   entry_t            new_ent;
   entry_t            sel_ent;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic [CNT_W-1:0]  tail;
   logic              sel_found;
   logic [IDX_W-1:0]  sel_idx;
   logic              issue;
   logic              dispatch;
   logic              a_bypass;
   logic              b_bypass;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign dispatch = in_instr_valid && !full;
   assign issue    = sel_found && out_ready;
   assign tail     = count_q - CNT_W'(issue);
   assign a_bypass = cdb_valid && !in_a_valid && (in_a_owner == cdb_tag);
   assign b_bypass = cdb_valid && !in_b_valid && (in_b_owner == cdb_tag);

   // Oldest ready entry, from registered state only
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!sel_found && ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      sel_ent = '0;
      if (sel_found) begin
         sel_ent = ent_q[sel_idx];
      end
   end

   assign out_valid   = sel_found;
   assign out_rob_idx = sel_ent.rob_idx;
   assign out_a_value = sel_ent.a_val;
   assign out_b_value = sel_ent.b_val;
   assign out_opcode  = sel_ent.opcode;
   assign out_i       = sel_ent.imm;

   // CDB wakeup applied before the shift so a moving entry keeps its capture
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         ent_w[i] = ent_q[i];
         if (cdb_valid && !ent_q[i].a_rdy && (ent_q[i].a_tag == cdb_tag)) begin
            ent_w[i].a_rdy = 1'b1;
            ent_w[i].a_val = cdb_value;
         end
         if (cdb_valid && !ent_q[i].b_rdy && (ent_q[i].b_tag == cdb_tag)) begin
            ent_w[i].b_rdy = 1'b1;
            ent_w[i].b_val = cdb_value;
         end
      end
   end

   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.rob_idx = in_rob_idx;
      new_ent.a_rdy   = in_a_valid || a_bypass;
      new_ent.a_val   = a_bypass ? cdb_value : in_a_value;
      new_ent.a_tag   = in_a_owner;
      new_ent.b_rdy   = in_b_valid || b_bypass;
      new_ent.b_val   = b_bypass ? cdb_value : in_b_value;
      new_ent.b_tag   = in_b_owner;
      new_ent.opcode  = in_opcode;
      new_ent.imm     = in_i;
   end

   // Collapse above the issued slot, then append the dispatch at the new tail
   always_comb begin
      count_d = count_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
         ent_d[i] = ent_q[i];
      end
      if (flush) begin
         count_d = '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_d[i].valid = 1'b0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (issue && (IDX_W'(i) >= sel_idx)) begin
               ent_d[i] = ent_w[i + 1];
            end else begin
               ent_d[i] = ent_w[i];
            end
         end
         ent_d[DEPTH-1] = ent_w[DEPTH-1];
         if (issue) begin
            ent_d[DEPTH-1].valid = 1'b0;
         end
         if (dispatch) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               if (CNT_W'(i) == tail) begin
                  ent_d[i] = new_ent;
               end
            end
         end
         count_d = count_q + CNT_W'(dispatch) - CNT_W'(issue);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fxu_reservation_station.sv
// Bench for fxu_reservation_station: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_fxu_reservation_station;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              in_instr_valid;
   logic [TAG_W-1:0]  in_rob_idx;
   logic              in_a_valid;
   logic [DATA_W-1:0] in_a_value;
   logic [TAG_W-1:0]  in_a_owner;
   logic              in_b_valid;
   logic [DATA_W-1:0] in_b_value;
   logic [TAG_W-1:0]  in_b_owner;
   logic [3:0]        in_opcode;
   logic [7:0]        in_i;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_value;
   logic              full;
   logic              out_valid;
   logic              out_ready;
   logic [TAG_W-1:0]  out_rob_idx;
   logic [DATA_W-1:0] out_a_value;
   logic [DATA_W-1:0] out_b_value;
   logic [3:0]        out_opcode;
   logic [7:0]        out_i;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [TAG_W-1:0]  rob;
      bit                ar;
      logic [DATA_W-1:0] av;
      logic [TAG_W-1:0]  at;
      bit                br;
      logic [DATA_W-1:0] bv;
      logic [TAG_W-1:0]  bt;
      logic [3:0]        op;
      logic [7:0]        imm;
   } ent_t;

   ent_t q[$];

   always #5 clk = ~clk;

   fxu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_instr_valid(in_instr_valid), .in_rob_idx(in_rob_idx),
      .in_a_valid(in_a_valid), .in_a_value(in_a_value), .in_a_owner(in_a_owner),
      .in_b_valid(in_b_valid), .in_b_value(in_b_value), .in_b_owner(in_b_owner),
      .in_opcode(in_opcode), .in_i(in_i),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .full(full), .out_valid(out_valid), .out_ready(out_ready),
      .out_rob_idx(out_rob_idx), .out_a_value(out_a_value), .out_b_value(out_b_value),
      .out_opcode(out_opcode), .out_i(out_i)
   );

   task automatic idle_inputs();
      flush          = 1'b0;
      in_instr_valid = 1'b0;
      in_rob_idx     = '0;
      in_a_valid     = 1'b0;
      in_a_value     = '0;
      in_a_owner     = '0;
      in_b_valid     = 1'b0;
      in_b_value     = '0;
      in_b_owner     = '0;
      in_opcode      = '0;
      in_i           = '0;
      cdb_valid      = 1'b0;
      cdb_tag        = '0;
      cdb_value      = '0;
   endtask

   task automatic set_dispatch(input logic [TAG_W-1:0] rob, input bit av_ok, input logic [DATA_W-1:0] a,
                               input logic [TAG_W-1:0] ao, input bit bv_ok, input logic [DATA_W-1:0] b,
                               input logic [TAG_W-1:0] bo, input logic [3:0] op);
      in_instr_valid = 1'b1;
      in_rob_idx     = rob;
      in_a_valid     = av_ok;
      in_a_value     = a;
      in_a_owner     = ao;
      in_b_valid     = bv_ok;
      in_b_value     = b;
      in_b_owner     = bo;
      in_opcode      = op;
      in_i           = {4'h5, op};
   endtask

   function automatic int model_sel();
      for (int k = 0; k < q.size(); k++) begin
         if (q[k].ar && q[k].br) return k;
      end
      return -1;
   endfunction

   // One clock edge; the model applies flush, else wakeup, removal and append
   task automatic tick();
      ent_t e;
      ent_t t;
      int sel;
      bit iss, disp, f, cv;
      logic [TAG_W-1:0]  ct;
      logic [DATA_W-1:0] cval;
      sel  = model_sel();
      iss  = (sel >= 0) && out_ready;
      disp = in_instr_valid && (q.size() < int'(DEPTH));
      f    = flush;
      cv   = cdb_valid;
      ct   = cdb_tag;
      cval = cdb_value;
      e.rob = in_rob_idx;
      e.ar  = in_a_valid || (cv && in_a_owner == ct);
      e.av  = in_a_valid ? in_a_value : (e.ar ? cval : in_a_value);
      e.at  = in_a_owner;
      e.br  = in_b_valid || (cv && in_b_owner == ct);
      e.bv  = in_b_valid ? in_b_value : (e.br ? cval : in_b_value);
      e.bt  = in_b_owner;
      e.op  = in_opcode;
      e.imm = in_i;
      @(posedge clk);
      if (f) begin
         q.delete();
      end else begin
         for (int k = 0; k < q.size(); k++) begin
            t = q[k];
            if (cv && !t.ar && t.at == ct) begin t.ar = 1'b1; t.av = cval; end
            if (cv && !t.br && t.bt == ct) begin t.br = 1'b1; t.bv = cval; end
            q[k] = t;
         end
         if (iss) q.delete(sel);
         if (disp) q.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #3;
      n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
      n_total++; if ({out_rob_idx, out_a_value, out_b_value, out_opcode, out_i} !== '0)
         $display("FAIL reset_outs: got %h want 0", {out_rob_idx, out_a_value, out_b_value, out_opcode, out_i});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_ready_dispatch();
      out_ready = 1'b1;
      set_dispatch(4'd3, 1'b1, 16'h0010, 4'd0, 1'b1, 16'h0020, 4'd0, 4'd2);
      tick();
      idle_inputs();
      n_total++; if (out_valid !== 1'b1) $display("FAIL rdy_valid: got %b want 1", out_valid); else n_pass++;
      n_total++; if ({out_rob_idx, out_a_value, out_b_value, out_opcode} !== {4'd3, 16'h0010, 16'h0020, 4'd2})
         $display("FAIL rdy_fields: got %h/%h/%h/%h want 3/0010/0020/2", out_rob_idx, out_a_value, out_b_value, out_opcode);
      else n_pass++;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL rdy_drain: got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_wakeup();
      out_ready = 1'b1;
      set_dispatch(4'd5, 1'b0, 16'h0000, 4'd2, 1'b1, 16'h0005, 4'd0, 4'd1);
      tick();
      idle_inputs();
      cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 16'hFFFF;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL wake_unrelated: got %b want 0", out_valid); else n_pass++;
      cdb_tag = 4'd2; cdb_value = 16'h1234;
      n_total++; if (out_valid !== 1'b0) $display("FAIL wake_same_cycle: got %b want 0", out_valid); else n_pass++;
      tick();
      idle_inputs();
      n_total++; if (out_valid !== 1'b1) $display("FAIL wake_valid: got %b want 1", out_valid); else n_pass++;
      n_total++; if ({out_rob_idx, out_a_value, out_b_value} !== {4'd5, 16'h1234, 16'h0005})
         $display("FAIL wake_fields: got %h/%h/%h want 5/1234/0005", out_rob_idx, out_a_value, out_b_value);
      else n_pass++;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL wake_drain: got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_bypass();
      out_ready = 1'b1;
      set_dispatch(4'd6, 1'b1, 16'h0001, 4'd0, 1'b0, 16'h0000, 4'd9, 4'd3);
      cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 16'hBEEF;
      tick();
      idle_inputs();
      n_total++; if (out_valid !== 1'b1) $display("FAIL byp_valid: got %b want 1", out_valid); else n_pass++;
      n_total++; if ({out_rob_idx, out_b_value} !== {4'd6, 16'hBEEF})
         $display("FAIL byp_fields: got %h/%h want 6/beef", out_rob_idx, out_b_value);
      else n_pass++;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL byp_drain: got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_oldest_first();
      out_ready = 1'b1;
      set_dispatch(4'd1, 1'b0, 16'h0000, 4'd4, 1'b1, 16'h0011, 4'd0, 4'd4);
      tick();
      set_dispatch(4'd2, 1'b1, 16'h0022, 4'd0, 1'b1, 16'h0022, 4'd0, 4'd5);
      tick();
      n_total++; if ({out_valid, out_rob_idx} !== {1'b1, 4'd2}) $display("FAIL order_first: got %b/%h want 1/2", out_valid, out_rob_idx); else n_pass++;
      set_dispatch(4'd3, 1'b1, 16'h0033, 4'd0, 1'b1, 16'h0033, 4'd0, 4'd6);
      tick();
      idle_inputs();
      n_total++; if ({out_valid, out_rob_idx} !== {1'b1, 4'd3}) $display("FAIL order_second: got %b/%h want 1/3", out_valid, out_rob_idx); else n_pass++;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL order_blocked: got %b want 0", out_valid); else n_pass++;
      cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_value = 16'h4444;
      tick();
      idle_inputs();
      n_total++; if ({out_valid, out_rob_idx, out_a_value} !== {1'b1, 4'd1, 16'h4444})
         $display("FAIL order_woken: got %b/%h/%h want 1/1/4444", out_valid, out_rob_idx, out_a_value);
      else n_pass++;
      tick();
   endtask

   task automatic test_full_backpressure();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_dispatch(4'(8 + k), 1'b1, 16'(k), 4'd0, 1'b1, 16'(k), 4'd0, 4'd7);
         tick();
         if (k == 2) begin
            n_total++; if (full !== 1'b0) $display("FAIL full_early: got %b want 0", full); else n_pass++;
         end
      end
      n_total++; if (full !== 1'b1) $display("FAIL full_set: got %b want 1", full); else n_pass++;
      set_dispatch(4'd12, 1'b1, 16'h00CC, 4'd0, 1'b1, 16'h00CC, 4'd0, 4'd7);
      tick();
      idle_inputs();
      n_total++; if ({full, out_rob_idx} !== {1'b1, 4'd8}) $display("FAIL full_hold: got %b/%h want 1/8", full, out_rob_idx); else n_pass++;
      out_ready = 1'b1;
      tick();
      n_total++; if (full !== 1'b0) $display("FAIL full_clear: got %b want 0", full); else n_pass++;
      for (int k = 9; k < 12; k++) begin
         n_total++; if ({out_valid, out_rob_idx} !== {1'b1, 4'(k)})
            $display("FAIL drain_order: got %b/%h want 1/%h", out_valid, out_rob_idx, 4'(k));
         else n_pass++;
         tick();
      end
      n_total++; if (out_valid !== 1'b0) $display("FAIL drain_dropped: got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_flush_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_dispatch(4'(k), 1'b1, 16'h0100, 4'd0, 1'b1, 16'h0200, 4'd0, 4'd1);
         tick();
      end
      n_total++; if (out_valid !== 1'b1) $display("FAIL flush_pre: got %b want 1", out_valid); else n_pass++;
      flush = 1'b1;
      tick();
      idle_inputs();
      n_total++; if ({full, out_valid} !== 2'b00) $display("FAIL flush_clear: got %b%b want 00", full, out_valid); else n_pass++;
      set_dispatch(4'd13, 1'b1, 16'h0ABC, 4'd0, 1'b1, 16'h0DEF, 4'd0, 4'd9);
      tick();
      idle_inputs();
      n_total++; if (out_valid !== 1'b1) $display("FAIL rst_pre: got %b want 1", out_valid); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if ({full, out_valid} !== 2'b00) $display("FAIL rst_async: got %b%b want 00", full, out_valid); else n_pass++;
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      int sel;
      bit exp_full;
      for (int c = 0; c < 800; c++) begin
         sel      = model_sel();
         exp_full = (q.size() == int'(DEPTH));
         n_total++; if (full !== exp_full) $display("FAIL rnd_full: cyc %0d got %b want %b", c, full, exp_full); else n_pass++;
         n_total++; if (out_valid !== (sel >= 0)) $display("FAIL rnd_valid: cyc %0d got %b want %b", c, out_valid, sel >= 0); else n_pass++;
         if (sel >= 0) begin
            n_total++;
            if ({out_rob_idx, out_a_value, out_b_value, out_opcode, out_i} !==
                {q[sel].rob, q[sel].av, q[sel].bv, q[sel].op, q[sel].imm})
               $display("FAIL rnd_fields: cyc %0d got %h/%h/%h/%h/%h want %h/%h/%h/%h/%h", c,
                        out_rob_idx, out_a_value, out_b_value, out_opcode, out_i,
                        q[sel].rob, q[sel].av, q[sel].bv, q[sel].op, q[sel].imm);
            else n_pass++;
         end
         in_instr_valid = ($urandom_range(99, 0) < 60);
         in_rob_idx     = TAG_W'($urandom);
         in_a_valid     = ($urandom_range(99, 0) < 50);
         in_a_value     = DATA_W'($urandom);
         in_a_owner     = TAG_W'($urandom_range(7, 0));
         in_b_valid     = ($urandom_range(99, 0) < 50);
         in_b_value     = DATA_W'($urandom);
         in_b_owner     = TAG_W'($urandom_range(7, 0));
         in_opcode      = 4'($urandom);
         in_i           = 8'($urandom);
         cdb_valid      = ($urandom_range(99, 0) < 50);
         cdb_tag        = TAG_W'($urandom_range(7, 0));
         cdb_value      = DATA_W'($urandom);
         out_ready      = ($urandom_range(99, 0) < 60);
         flush          = ($urandom_range(99, 0) < 2);
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_ready_dispatch();
      test_wakeup();
      test_bypass();
      test_oldest_first();
      test_full_backpressure();
      test_flush_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fxu_reservation_station.md
Name: fxu_reservation_station

Overview:
- Per-FXU reservation station that sits directly downstream of the instruction buffer's fxu_0/fxu_1 dispatch ports. One instance is used per FXU.
- Holds dispatched instructions whose operands may still be pending. Pending operands are captured from the result broadcast bus (CDB) by ROB-index tag.
- Issues the oldest fully-ready entry to the FXU.
- Its full output drives the instruction buffer's fxu_N_full input.

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAG_W, 4, ROB index / owner tag width.
- DATA_W, 16, operand and result width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries (branch mispredict).
- in_instr_valid  in  1  dispatch strobe.
- in_rob_idx  in  TAG_W  destination ROB index.
- in_a_valid  in  1  operand A value already resolved.
- in_a_value  in  DATA_W  operand A value.
- in_a_owner  in  TAG_W  ROB tag producing A when not valid.
- in_b_valid  in  1  operand B value already resolved.
- in_b_value  in  DATA_W  operand B value.
- in_b_owner  in  TAG_W  ROB tag producing B when not valid.
- in_opcode  in  4  opcode.
- in_i  in  8  immediate.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  ROB index of broadcast result.
- cdb_value  in  DATA_W  broadcast result.
- full  out  1  all DEPTH entries occupied.
- out_valid  out  1  issue candidate present.
- out_ready  in  1  FXU accepts issue this cycle.
- out_rob_idx  out  TAG_W  issued ROB index.
- out_a_value  out  DATA_W  issued operand A.
- out_b_value  out  DATA_W  issued operand B.
- out_opcode  out  4  issued opcode.
- out_i  out  8  issued immediate.

Behaviour:
- Storage: collapsing queue.
  - Entry 0 is the oldest; occupied entries are always contiguous from 0.
  - count is 0..DEPTH.
  - Each entry holds: valid, rob_idx, a_rdy, a_val, a_tag, b_rdy, b_val, b_tag, opcode, imm.
- Reset (rst_n low, asynchronous): all entry valid bits 0, count 0, full 0, out_valid 0. Data fields are don't-care; outputs other than full and out_valid read 0.
- full:
  - Registered-state function: full = (count == DEPTH).
  - It does not anticipate a same-cycle issue. A dispatch attempted while full is dropped with no state change; upstream must not issue it.
- Dispatch (in_instr_valid & ~full): at the clock edge the instruction is written to position count, or count-1 if an issue also occurs that edge.
- Dispatch-time CDB bypass: if cdb_valid, in_X_valid == 0 and cdb_tag == in_X_owner, the entry is written with X_rdy = 1 and X_val = cdb_value. Otherwise the entry is written from the dispatch inputs.
- Wakeup: every occupied entry with X_rdy == 0 and X_tag == cdb_tag (with cdb_valid) sets X_rdy = 1 and X_val = cdb_value at the edge. Operands A and B wake independently; both may wake in the same cycle.
- Select:
  - Combinational from registered state only.
  - out_valid = OR over occupied entries of (a_rdy & b_rdy).
  - The selected entry is the lowest-index ready entry; out_* carry its fields.
  - A wakeup in cycle N makes the entry selectable in cycle N+1, never in cycle N.
- Issue (out_valid & out_ready at edge):
  - The selected entry is removed; entries above it shift down by one, preserving order.
  - With a simultaneous dispatch, the new entry lands at the new tail.
  - out_* must hold stable while out_valid & ~out_ready.
- Latency: a dispatch with both operands ready gives out_valid in the next cycle.
- Tag consistency: a CDB hit on an entry that is shifting during the same edge must be applied to the shifted copy; no wakeup may be lost.
- Flush: takes priority over dispatch and issue. All valid bits clear and count becomes 0 at the edge; full and out_valid read 0 in the next cycle.
- Reset mid-operation: asynchronous clear, same state as the reset item above.
- count arithmetic: count_next = count + dispatch_accepted − issue_fired, which stays within 0..DEPTH.

Test Plan:
- Ready dispatch: dispatch rob 3, a_valid=1 a=0x0010, b_valid=1 b=0x0020, opcode 2, out_ready=1 → next cycle out_valid=1, out_rob_idx=3, a=0x0010, b=0x0020; following cycle out_valid=0, count=0.
- Wakeup: dispatch rob 5 with a_owner=2 (a_valid=0); two cycles later cdb_valid tag=2 value=0x1234 → out_valid rises the cycle after the broadcast with out_a_value=0x1234; an unrelated tag=7 broadcast earlier causes no wakeup.
- Dispatch bypass: dispatch with b_owner=9, b_valid=0 while cdb tag=9 value=0xBEEF in the same cycle → next cycle out_valid=1, out_b_value=0xBEEF.
- Oldest-first and collapse: dispatch rob 1 (waiting on tag 4), rob 2 (ready), rob 3 (ready); out_ready=1 → issue order 2, then 3; wake tag 4 → rob 1 issues next; ordering survives the shifts.
- Full and back-pressure: out_ready=0, dispatch 4 ready entries → full=1 after the 4th edge; a 5th dispatch is dropped; out_rob_idx stays at the first entry; set out_ready=1 → full=0 one cycle later, entries drain in order.
- Flush and reset: with 3 entries occupied, assert flush → next cycle full=0, out_valid=0; dispatch again and pulse rst_n low asynchronously mid-cycle → out_valid and full go 0 immediately.
